// File: rtl/instruction_loader_pkg.sv
// Shared processor package: loader FSM encoding and instruction byte count.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } loader_state_e;

  localparam int unsigned BytesPerInstr = 4;

endpackage

// File: rtl/instruction_loader.sv
// Streams program bytes into instruction memory, assembling little-endian
// 32-bit words and writing them to consecutive word addresses from 0.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned WORDSIZE         = 64,
  parameter int unsigned INSTRUCTION_SIZE = 32,
  parameter int unsigned MEMORY_SIZE      = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 length,
  input  logic                        byte_valid,
  input  logic [7:0]                  byte_data,
  output logic                        byte_ready,
  output logic                        mem_we,
  output logic [WORDSIZE-1:0]         mem_addr,
  output logic [INSTRUCTION_SIZE-1:0] mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  localparam int unsigned CntW     = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int unsigned ByteCntW = $clog2(BytesPerInstr);
  localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(BytesPerInstr - 1);

  loader_state_e               state_q, state_d;
  logic [15:0]                 length_q, length_d;
  logic [CntW-1:0]             word_cnt_q, word_cnt_d;
  logic [ByteCntW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [INSTRUCTION_SIZE-1:0] asm_q, asm_d;
  logic [WORDSIZE-1:0]         mem_addr_q, mem_addr_d;
  logic [INSTRUCTION_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                        error_q, error_d;

  always_comb begin
    state_d     = state_q;
    length_d    = length_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((length != 16'd0) && (32'(length) <= MEMORY_SIZE)) begin
            length_d   = length;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = StRecv;
          end else begin
            error_d = 1'b1;
            state_d = StDone;
          end
        end
      end
      StRecv: begin
        if (byte_valid) begin
          asm_d[{byte_cnt_q, 3'b000} +: 8] = byte_data;
          byte_cnt_d = byte_cnt_q + ByteCntW'(1);
          if (byte_cnt_q == LastByte) begin
            // Output registers load here so they hold after the write cycle.
            mem_addr_d  = WORDSIZE'(word_cnt_q);
            mem_wdata_d = asm_d;
            state_d     = StWrite;
          end
        end
      end
      StWrite: begin
        if (32'(word_cnt_q) + 32'd1 == 32'(length_q)) begin
          state_d = StDone;
        end else begin
          word_cnt_d = word_cnt_q + CntW'(1);
          state_d    = StRecv;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      length_q    <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      length_q    <= length_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      error_q     <= error_d;
    end
  end

  assign byte_ready = (state_q == StRecv);
  assign mem_we     = (state_q == StWrite);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StDone) && error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: write scoreboard fed by a negedge
// monitor, one task per scenario.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] length;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [63:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int done_cnt, err_cnt, ready_cnt, ready_in_wr;

  always #5 clk = ~clk;

  instruction_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .length     (length),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      if (byte_ready) ready_in_wr++;
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (byte_ready) ready_cnt++;
  end

  task automatic clr_mon();
    wq_addr.delete();
    wq_data.delete();
    done_cnt    = 0;
    err_cnt     = 0;
    ready_cnt   = 0;
    ready_in_wr = 0;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    start  = 1'b1;
    length = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Presents one byte and returns just after the edge that transfers it.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; length = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({byte_ready, mem_we, busy, done, error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000", {byte_ready, mem_we, busy, done, error});
    end
    total++;
    if (mem_addr !== 64'd0 || mem_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_bus got addr=%0h data=%0h want 0/0", mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_word();
    bit ok;
    int to = 0;
    logic [7:0] b[4] = '{8'h33, 8'h01, 8'h20, 8'h00};
    clr_mon();
    pulse_start(16'd1);
    for (int k = 0; k < 4; k++) begin
      send_byte(b[k], ok);
      if (!ok) to++;
    end
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 64'd0 || mem_wdata !== 32'h0020_0133) begin
      bad++;
      $display("FAIL t1_latency got we=%b addr=%0h data=%0h want 1/0/00200133",
               mem_we, mem_addr, mem_wdata);
    end
    wait_idle(ok);
    if (!ok) to++;
    total++;
    if (to !== 0) begin bad++; $display("FAIL t1_timeout got=%0d want=0", to); end
    total++;
    if (wq_addr.size() !== 1 || wq_data.size() !== 1) begin
      bad++;
      $display("FAIL t1_writes got=%0d want=1", wq_addr.size());
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL t1_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    total++;
    if (mem_addr !== 64'd0 || mem_wdata !== 32'h0020_0133) begin
      bad++;
      $display("FAIL t1_hold got addr=%0h data=%0h want 0/00200133", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_toggle_valid();
    bit ok;
    int to = 0;
    logic [31:0] w[3] = '{32'h1122_3344, 32'hAABB_CCDD, 32'hDEAD_BEEF};
    clr_mon();
    pulse_start(16'd3);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(w[i][8*k +: 8], ok);
        if (!ok) to++;
        @(posedge clk);
        #1;
      end
    end
    wait_idle(ok);
    if (!ok) to++;
    total++;
    if (to !== 0) begin bad++; $display("FAIL t2_timeout got=%0d want=0", to); end
    total++;
    if (wq_addr.size() !== 3) begin
      bad++;
      $display("FAIL t2_writes got=%0d want=3", wq_addr.size());
    end
    for (int i = 0; i < 3 && i < wq_addr.size(); i++) begin
      total++;
      if (wq_addr[i] !== 64'(i) || wq_data[i] !== w[i]) begin
        bad++;
        $display("FAIL t2_word%0d got addr=%0h data=%0h want %0h/%0h",
                 i, wq_addr[i], wq_data[i], i, w[i]);
      end
    end
    total++;
    if (ready_in_wr !== 0) begin
      bad++;
      $display("FAIL t2_ready_in_write got=%0d want=0", ready_in_wr);
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL t2_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
    total++;
    if (mem_addr !== 64'd2 || mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL t2_hold got addr=%0h data=%0h want 2/deadbeef", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_bad_length();
    bit ok;
    logic [15:0] lens[2] = '{16'd0, 16'd1025};
    for (int i = 0; i < 2; i++) begin
      clr_mon();
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      pulse_start(lens[i]);
      wait_idle(ok);
      byte_valid = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL t3_timeout len=%0d got=0 want=1", lens[i]); end
      total++;
      if (done_cnt !== 1 || err_cnt !== 1) begin
        bad++;
        $display("FAIL t3_done len=%0d got done=%0d err=%0d want 1/1",
                 lens[i], done_cnt, err_cnt);
      end
      total++;
      if (wq_addr.size() !== 0 || ready_cnt !== 0) begin
        bad++;
        $display("FAIL t3_quiet len=%0d got writes=%0d ready=%0d want 0/0",
                 lens[i], wq_addr.size(), ready_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int to = 0;
    logic [7:0] b[4] = '{8'h13, 8'h00, 8'h00, 8'h00};
    clr_mon();
    pulse_start(16'd2);
    for (int k = 0; k < 6; k++) begin
      send_byte(8'(8'h40 + k), ok);
      if (!ok) to++;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({byte_ready, mem_we, busy, done, error} !== 5'b0 || mem_addr !== 64'd0 ||
        mem_wdata !== 32'd0) begin
      bad++;
      $display("FAIL t4_reset_outs got flags=%b addr=%0h data=%0h want 0/0/0",
               {byte_ready, mem_we, busy, done, error}, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (wq_addr.size() !== 1 || done_cnt !== 0) begin
      bad++;
      $display("FAIL t4_after_reset got writes=%0d done=%0d want 1/0", wq_addr.size(), done_cnt);
    end
    @(posedge clk);
    #1;
    clr_mon();
    pulse_start(16'd1);
    for (int k = 0; k < 4; k++) begin
      send_byte(b[k], ok);
      if (!ok) to++;
    end
    wait_idle(ok);
    if (!ok) to++;
    total++;
    if (to !== 0) begin bad++; $display("FAIL t4_timeout got=%0d want=0", to); end
    total++;
    if (wq_addr.size() !== 1 || done_cnt !== 1) begin
      bad++;
      $display("FAIL t4_reload got writes=%0d done=%0d want 1/1", wq_addr.size(), done_cnt);
    end else if (wq_addr[0] !== 64'd0 || wq_data[0] !== 32'h0000_0013) begin
      bad++;
      $display("FAIL t4_reload_word got addr=%0h data=%0h want 0/13", wq_addr[0], wq_data[0]);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int to = 0;
    clr_mon();
    pulse_start(16'd2);
    for (int k = 1; k <= 8; k++) begin
      send_byte(8'(k), ok);
      if (!ok) to++;
      // Competing request with a shorter length while mid-load.
      if (k == 2 || k == 5) pulse_start(16'd1);
    end
    wait_idle(ok);
    if (!ok) to++;
    total++;
    if (to !== 0) begin bad++; $display("FAIL t5_timeout got=%0d want=0", to); end
    total++;
    if (wq_addr.size() !== 2 || done_cnt !== 1) begin
      bad++;
      $display("FAIL t5_count got writes=%0d done=%0d want 2/1", wq_addr.size(), done_cnt);
    end else if (wq_data[0] !== 32'h0403_0201 || wq_data[1] !== 32'h0807_0605 ||
                 wq_addr[1] !== 64'd1) begin
      bad++;
      $display("FAIL t5_words got %0h@%0h %0h@%0h want 04030201@0 08070605@1",
               wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
    end
  endtask

  task automatic test_full_memory();
    bit ok;
    int to = 0;
    int nbad = 0;
    logic [31:0] exp_w[1024];
    clr_mon();
    for (int i = 0; i < 1024; i++) exp_w[i] = $urandom;
    pulse_start(16'd1024);
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(exp_w[i][8*k +: 8], ok);
        if (!ok) to++;
      end
    end
    wait_idle(ok);
    if (!ok) to++;
    total++;
    if (to !== 0) begin bad++; $display("FAIL t6_timeout got=%0d want=0", to); end
    total++;
    if (wq_addr.size() !== 1024) begin
      bad++;
      $display("FAIL t6_writes got=%0d want=1024", wq_addr.size());
    end else if (wq_addr[1023] !== 64'd1023) begin
      bad++;
      $display("FAIL t6_last_addr got=%0h want=3ff", wq_addr[1023]);
    end
    for (int i = 0; i < wq_addr.size() && i < 1024; i++) begin
      total++;
      if (wq_addr[i] !== 64'(i) || wq_data[i] !== exp_w[i]) begin
        bad++;
        nbad++;
        if (nbad <= 8)
          $display("FAIL t6_word%0d got addr=%0h data=%0h want %0h/%0h",
                   i, wq_addr[i], wq_data[i], i, exp_w[i]);
      end
    end
    total++;
    if (done_cnt !== 1 || err_cnt !== 0) begin
      bad++;
      $display("FAIL t6_done got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_toggle_valid();
    test_bad_length();
    test_reset_mid_load();
    test_start_ignored();
    test_full_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
